// File: rtl/mdu_seq_if.sv
// mdu_seq_if: E-stage operands/opcode in, HI/LO state and stall/busy out.
interface mdu_seq_if;
  logic [31:0] D1;
  logic [31:0] D2;
  logic [3:0]  XALUOp;
  logic        MD_Use_D;
  logic        Busy;
  logic        Stall_D;
  logic [31:0] XALU_Out;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output D1, D2, XALUOp, MD_Use_D, input Busy, Stall_D, XALU_Out, HI, LO);
  modport slave (input D1, D2, XALUOp, MD_Use_D, output Busy, Stall_D, XALU_Out, HI, LO);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: fixed-latency multiply/divide unit with HI/LO and pipeline stall generation.
module mdu_seq #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input logic         clk,
  input logic         reset,
  mdu_seq_if.slave    bus
);
  localparam int LMAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW = ($clog2(LMAX + 1) < 4) ? 4 : $clog2(LMAX + 1);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_op;
  logic [31:0]   r_a, r_b, r_hi, r_lo;
  logic          w_busy, w_start, w_start_div, w_div, w_sdiv, w_smul, w_na, w_nb;
  logic [63:0]   w_prod;
  logic [31:0]   w_da, w_db, w_uq, w_ur, w_q, w_r;
  assign w_busy      = r_state == RUN;
  assign w_start     = bus.XALUOp >= 4'd1 && bus.XALUOp <= 4'd4;
  assign w_start_div = bus.XALUOp == 4'd3 || bus.XALUOp == 4'd4;
  assign w_div       = r_op == 4'd3 || r_op == 4'd4;
  assign w_sdiv      = r_op == 4'd3;
  assign w_smul      = r_op == 4'd1;
  assign w_prod = w_smul ? {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b}
                         : {32'd0, r_a} * {32'd0, r_b};
  // signed divide runs on magnitudes; quotient truncates toward zero, remainder follows dividend
  assign w_na = w_sdiv & r_a[31];
  assign w_nb = w_sdiv & r_b[31];
  assign w_da = w_na ? -r_a : r_a;
  assign w_db = w_nb ? -r_b : r_b;
  assign w_uq = (w_db == 32'd0) ? 32'd0 : w_da / w_db;
  assign w_ur = (w_db == 32'd0) ? 32'd0 : w_da % w_db;
  assign w_q  = (w_na ^ w_nb) ? -w_uq : w_uq;
  assign w_r  = w_na ? -w_ur : w_ur;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CW'(1)) begin
        r_state <= IDLE;
        if (!w_div) {r_hi, r_lo} <= w_prod;
        else if (r_b != 32'd0) begin
          r_hi <= w_r;
          r_lo <= w_q;
        end
      end
    end else if (w_start) begin
      r_state <= RUN;
      r_cnt   <= w_start_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      r_op    <= bus.XALUOp;
      r_a     <= bus.D1;
      r_b     <= bus.D2;
    end else if (bus.XALUOp == 4'd7) r_hi <= bus.D1;
    else if (bus.XALUOp == 4'd8) r_lo <= bus.D1;
  end
  assign bus.Busy     = w_busy;
  assign bus.Stall_D  = bus.MD_Use_D & (w_busy | w_start);
  assign bus.XALU_Out = (bus.XALUOp == 4'd5) ? r_hi : (bus.XALUOp == 4'd6) ? r_lo : 32'd0;
  assign bus.HI       = r_hi;
  assign bus.LO       = r_lo;
endmodule
